reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter_if.sv | 26 ++
 rtl/reg_wb_arbiter.sv | 91 +++++++++
 tb/tb_reg_wb_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus shared by two requesters and the arbiter that feeds the
// register-file write port.
interface reg_wb_arbiter_if;
  logic        a_valid_i;
  logic [4:0]  a_addr_i;
  logic [31:0] a_data_i;
  logic        a_ready_o;
  logic        b_valid_i;
  logic [4:0]  b_addr_i;
  logic [31:0] b_data_i;
  logic        b_ready_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic [15:0] conflict_cnt_o;

  modport slave (
    input  a_valid_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i,
    output a_ready_o, b_ready_o, RegWrite_o, RDaddr_o, RDdata_o, conflict_cnt_o
  );

  modport master (
    output a_valid_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i,
    input  a_ready_o, b_ready_o, RegWrite_o, RDaddr_o, RDdata_o, conflict_cnt_o
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Two-requester register-file writeback arbiter: A-priority by default, with a
// starvation guard that hands B priority after three consecutive denials.
module reg_wb_arbiter (
  input  logic            clk_i,
  input  logic            rst_n,
  reg_wb_arbiter_if.slave bus
);

  typedef enum logic {PRIO_A, PRIO_B} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  starv_reg, starv_next;
  logic [15:0] conflict_reg;
  logic        regwrite_reg;
  logic [4:0]  rdaddr_reg;
  logic [31:0] rddata_reg;

  logic        a_grant, b_grant, xfer, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  // Grants depend only on valids and state; both are held low during reset.
  always_comb begin
    a_grant    = 1'b0;
    b_grant    = 1'b0;
    state_next = state_reg;
    starv_next = starv_reg;

    if (rst_n) begin
      case (state_reg)
        PRIO_A: begin
          a_grant = bus.a_valid_i;
          b_grant = bus.b_valid_i & ~bus.a_valid_i;
        end
        PRIO_B: begin
          b_grant = bus.b_valid_i;
          a_grant = bus.a_valid_i & ~bus.b_valid_i;
        end
        default: ;
      endcase
    end

    if (!bus.b_valid_i || b_grant) begin
      starv_next = 2'd0;
    end else if (starv_reg != 2'd3) begin
      starv_next = starv_reg + 2'd1;
    end

    case (state_reg)
      PRIO_A: if (bus.b_valid_i && !b_grant && starv_reg >= 2'd2) state_next = PRIO_B;
      PRIO_B: if (b_grant || !bus.b_valid_i) state_next = PRIO_A;
      default: state_next = PRIO_A;
    endcase
  end

  assign xfer    = a_grant | b_grant;
  assign wr_addr = b_grant ? bus.b_addr_i : bus.a_addr_i;
  assign wr_data = b_grant ? bus.b_data_i : bus.a_data_i;
  // Writes to $0 are accepted but dropped, leaving the address/data regs untouched.
  assign wr_en   = xfer && (wr_addr != 5'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_reg    <= PRIO_A;
      starv_reg    <= 2'd0;
      conflict_reg <= 16'd0;
      regwrite_reg <= 1'b0;
      rdaddr_reg   <= 5'd0;
      rddata_reg   <= 32'd0;
    end else begin
      state_reg    <= state_next;
      starv_reg    <= starv_next;
      regwrite_reg <= wr_en;
      if (wr_en) begin
        rdaddr_reg <= wr_addr;
        rddata_reg <= wr_data;
      end
      if (bus.a_valid_i && bus.b_valid_i && conflict_reg != 16'hFFFF) begin
        conflict_reg <= conflict_reg + 16'd1;
      end
    end
  end

  assign bus.a_ready_o      = a_grant;
  assign bus.b_ready_o      = b_grant;
  assign bus.RegWrite_o     = regwrite_reg;
  assign bus.RDaddr_o       = rdaddr_reg;
  assign bus.RDdata_o       = rddata_reg;
  assign bus.conflict_cnt_o = conflict_reg;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: grant order, writeback outputs, $0 filter,
// starvation guard, reset behaviour and conflict counter saturation.
module tb_reg_wb_arbiter;

  logic clk_i = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  reg_wb_arbiter_if bus ();

  reg_wb_arbiter dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Starvation-clear pattern: B valid per cycle and whether B must win.
  logic tbl_b_valid [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic tbl_b_win   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] addr, input logic [31:0] data);
    bus.a_valid_i = v;
    bus.a_addr_i  = addr;
    bus.a_data_i  = data;
  endtask

  task automatic set_b(input logic v, input logic [4:0] addr, input logic [31:0] data);
    bus.b_valid_i = v;
    bus.b_addr_i  = addr;
    bus.b_data_i  = data;
  endtask

  task automatic check_grant(input string tag, input logic exp_a, input logic exp_b);
    #1;
    check_eq({tag, "_a_ready"}, 32'(bus.a_ready_o), 32'(exp_a));
    check_eq({tag, "_b_ready"}, 32'(bus.b_ready_o), 32'(exp_b));
  endtask

  task automatic check_out(input string tag, input logic we, input logic [4:0] addr,
                           input logic [31:0] data);
    check_eq({tag, "_we"},   32'(bus.RegWrite_o), 32'(we));
    check_eq({tag, "_addr"}, 32'(bus.RDaddr_o),   32'(addr));
    check_eq({tag, "_data"}, bus.RDdata_o,        data);
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    next_cycle();
    next_cycle();
    check_out("reset", 1'b0, 5'd0, 32'd0);
    check_eq("reset_conflict", 32'(bus.conflict_cnt_o), 32'd0);

    // Collision held during reset: no grants, no counting.
    set_a(1'b1, 5'd1, 32'h1);
    set_b(1'b1, 5'd2, 32'h2);
    check_grant("in_reset", 1'b0, 1'b0);
    next_cycle();
    check_eq("in_reset_conflict", 32'(bus.conflict_cnt_o), 32'd0);
    rst_n = 1'b1;
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    next_cycle();

    // A alone.
    set_a(1'b1, 5'd5, 32'h1234);
    check_grant("a_only", 1'b1, 1'b0);
    next_cycle();
    check_out("a_only", 1'b1, 5'd5, 32'h1234);
    set_a(1'b0, 5'd0, 32'd0);
    check_grant("idle", 1'b0, 1'b0);
    next_cycle();
    check_out("idle_hold", 1'b0, 5'd5, 32'h1234);

    // $0 write accepted but dropped.
    set_a(1'b1, 5'd0, 32'hFFFF_FFFF);
    check_grant("zero", 1'b1, 1'b0);
    next_cycle();
    check_out("zero", 1'b0, 5'd5, 32'h1234);

    // Sustained collision: A, A, A, B, A.
    set_a(1'b1, 5'd3, 32'hAAAA);
    set_b(1'b1, 5'd7, 32'hBEEF);
    for (int i = 1; i <= 5; i++) begin
      check_grant($sformatf("coll_c%0d", i), i != 4, i == 4);
      next_cycle();
      if (i == 4) check_out("coll_c4", 1'b1, 5'd7, 32'hBEEF);
      else        check_out($sformatf("coll_c%0d", i), 1'b1, 5'd3, 32'hAAAA);
      if (i == 4) check_eq("coll_conflict4", 32'(bus.conflict_cnt_o), 32'd4);
    end
    check_eq("coll_conflict5", 32'(bus.conflict_cnt_o), 32'd5);
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    next_cycle();

    // B dropping for one cycle restarts the starvation count.
    set_a(1'b1, 5'd4, 32'h4444);
    for (int i = 0; i < 7; i++) begin
      set_b(tbl_b_valid[i], 5'd8, 32'h8888);
      check_grant($sformatf("starv_clr%0d", i), ~tbl_b_win[i], tbl_b_win[i]);
      next_cycle();
    end
    check_out("starv_clr_last", 1'b1, 5'd8, 32'h8888);
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    next_cycle();

    // B alone in A-priority.
    set_b(1'b1, 5'd12, 32'hC0DE);
    check_grant("b_only", 1'b0, 1'b1);
    next_cycle();
    check_out("b_only", 1'b1, 5'd12, 32'hC0DE);

    // Enter B priority, then B withdraws: priority must fall back to A.
    set_a(1'b1, 5'd6, 32'h6666);
    set_b(1'b1, 5'd9, 32'h9999);
    for (int i = 0; i < 3; i++) begin
      check_grant($sformatf("drop_c%0d", i), 1'b1, 1'b0);
      next_cycle();
    end
    set_b(1'b0, 5'd9, 32'h9999);
    check_grant("drop_b_gone", 1'b1, 1'b0);
    next_cycle();
    set_b(1'b1, 5'd9, 32'h9999);
    check_grant("drop_back_prio_a", 1'b1, 1'b0);
    next_cycle();
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    next_cycle();

    // Reset mid-stream after reaching B priority.
    set_a(1'b1, 5'd10, 32'hA0A0);
    set_b(1'b1, 5'd11, 32'hB0B0);
    for (int i = 0; i < 3; i++) begin
      check_grant($sformatf("rst_pre%0d", i), 1'b1, 1'b0);
      next_cycle();
    end
    check_out("rst_pre_write", 1'b1, 5'd10, 32'hA0A0);
    rst_n = 1'b0;
    check_grant("rst_active", 1'b0, 1'b0);
    next_cycle();
    check_out("rst_mid", 1'b0, 5'd0, 32'd0);
    check_eq("rst_mid_conflict", 32'(bus.conflict_cnt_o), 32'd0);
    check_grant("rst_held", 1'b0, 1'b0);
    rst_n = 1'b1;
    check_grant("rst_release_prio_a", 1'b1, 1'b0);
    next_cycle();
    check_out("rst_release", 1'b1, 5'd10, 32'hA0A0);

    // Conflict counter saturation.
    for (int i = 0; i < 70000 && bus.conflict_cnt_o != 16'hFFFF; i++) next_cycle();
    check_eq("sat_reached", 32'(bus.conflict_cnt_o), 32'hFFFF);
    for (int i = 0; i < 4; i++) next_cycle();
    check_eq("sat_hold", 32'(bus.conflict_cnt_o), 32'hFFFF);
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0);
    next_cycle();
    check_eq("sat_idle", 32'(bus.conflict_cnt_o), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
